// File: rtl/raycast_pkg.sv
// raycast_pkg: shared types and screen constants for the raycasting pipeline.
package raycast_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, DRAIN, WAIT_SWAP} seq_state_t;
    localparam int NUM_COLS_DEFAULT = 320;
    localparam int COL_W = 9;
    localparam int SCREEN_HEIGHT = 240;
endpackage

// File: rtl/col_issue_counter.sv
// col_issue_counter: valid/ready column index generator, 0..NUM_COLS-1 with tlast.
module col_issue_counter #(
    parameter int NUM_COLS = 320,
    parameter int HC_WIDTH = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                tready_i,
    output logic                tvalid_o,
    output logic [HC_WIDTH-1:0] hcount_o,
    output logic                tlast_o,
    output logic                done_o
);
    logic                valid_q, valid_d, last_q, last_d, hs;
    logic [HC_WIDTH-1:0] cnt_q, cnt_d;
    assign hs = valid_q & tready_i;
    // tlast is precomputed one index early so it stays a plain register output
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (start_i) begin
            valid_d = 1'b1;
            cnt_d   = '0;
            last_d  = (NUM_COLS == 1);
        end else if (hs) begin
            valid_d = !last_q;
            cnt_d   = last_q ? '0 : cnt_q + 1'b1;
            last_d  = !last_q && (cnt_q == HC_WIDTH'(NUM_COLS - 2));
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
    assign tvalid_o = valid_q;
    assign hcount_o = cnt_q;
    assign tlast_o  = last_q;
    assign done_o   = hs & last_q;
endmodule

// File: rtl/ray_frame_sequencer.sv
// ray_frame_sequencer: per-frame pose latch, column issue, drain and swap scheduler.
// Optional DRAIN watchdog enabled by defining RAYSEQ_WATCHDOG_EN.
module ray_frame_sequencer
    import raycast_pkg::*;
#(
    parameter int NUM_COLS        = NUM_COLS_DEFAULT,
    parameter int HC_WIDTH        = COL_W,
    parameter int DROP_WIDTH      = 8,
    parameter int WATCHDOG_CYCLES = 1048576
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic                  new_frame_in,
    input  logic                  video_last_pixel_in,
    input  logic                  render_done_in,
    input  logic                  col_tready_in,
    output logic                  col_tvalid_out,
    output logic [HC_WIDTH-1:0]   col_hcount_out,
    output logic                  col_tlast_out,
    output logic                  pose_latch_out,
    output logic                  swap_out,
    output logic                  busy_out,
    output logic [DROP_WIDTH-1:0] drop_count_out,
    output logic                  timeout_out
);
    seq_state_t            state_q, state_d;
    logic                  pose_q, swap_q, swap_d, busy_q, nf_drop, col_done, wd_expire;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    col_issue_counter #(.NUM_COLS(NUM_COLS), .HC_WIDTH(HC_WIDTH)) u_cols (
        .clk      (pixel_clk_in),
        .rst      (rst_in),
        .start_i  (state_q == LATCH),
        .tready_i (col_tready_in),
        .tvalid_o (col_tvalid_out),
        .hcount_o (col_hcount_out),
        .tlast_o  (col_tlast_out),
        .done_o   (col_done)
    );

    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        nf_drop = new_frame_in;
        case (state_q)
            IDLE: begin
                nf_drop = 1'b0;
                if (new_frame_in) state_d = LATCH;
            end
            LATCH:   state_d = ISSUE;
            ISSUE:   if (col_done) state_d = DRAIN;
            DRAIN:   state_d = render_done_in ? WAIT_SWAP : (wd_expire ? IDLE : DRAIN);
            // a new frame landing on the swap cycle is accepted, not dropped
            WAIT_SWAP: if (video_last_pixel_in) begin
                swap_d  = 1'b1;
                nf_drop = 1'b0;
                state_d = new_frame_in ? LATCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
        drop_d = (nf_drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pose_q  <= 1'b0;
            swap_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pose_q  <= state_d == LATCH;
            swap_q  <= swap_d;
            busy_q  <= state_d != IDLE;
            drop_q  <= drop_d;
        end
    end

`ifdef RAYSEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    assign wd_expire = wd_q == WD_W'(WATCHDOG_CYCLES - 1);
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= (state_q == DRAIN) ? wd_q + 1'b1 : '0;
            timeout_q <= timeout_q | (state_q == DRAIN && !render_done_in && wd_expire);
        end
    end
    assign timeout_out = timeout_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_out = 1'b0;
`endif

    assign pose_latch_out = pose_q;
    assign swap_out       = swap_q;
    assign busy_out       = busy_q;
    assign drop_count_out = drop_q;
endmodule
